arm_muldiv: RTL and testbench

Iterative multiply/divide unit for the ARM core. It extends the single-cycle ALU with 2W-bit multiply (UMULL/SMULL, with MUL taken from the low word) and with UDIV/SDIV. Operands are captured on `start`. The unit iterates one bit per cycle, applies a sign fix-up, and pulses `done` with a stable result. The core datapath stalls its PC and register write while `busy` is high, then writes `result_lo`/`result_hi` on `done`.

---
 rtl/arm_muldiv_pkg.sv | 33 +++
 rtl/arm_muldiv.sv | 151 +++++++++++++++
 tb/tb_arm_muldiv.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/arm_muldiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
//   muldiv_op_t    : operation encoding presented on the op port
//   muldiv_state_t : sequencer states
//   cond_neg       : conditional two's-complement negate, used for the
//                    operand magnitudes at capture and for the sign fix-up
package arm_muldiv_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  // Working width of cond_neg; callers zero-extend in and truncate out.
  localparam int unsigned MAX_W         = 128;

  typedef enum logic [1:0] {
    UMUL = 2'b00,
    SMUL = 2'b01,
    UDIV = 2'b10,
    SDIV = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } muldiv_state_t;

  // Negating modulo 2^MAX_W and truncating gives the same low bits as
  // negating at the narrower width, so one helper serves all widths.
  function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] x,
                                                input logic             en);
    return en ? (~x + MAX_W'(1)) : x;
  endfunction

endpackage

// File: rtl/arm_muldiv.sv
// Iterative multiply/divide unit: one bit per cycle over a shared 2W
// accumulator, followed by one sign fix-up cycle.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   start, op, a, b      : request, operation, operands (captured on start)
//   busy                 : high in CALC and FIX (decoded from state)
//   done                 : one-cycle pulse when the result is presented
//   result_lo/result_hi  : product low/high word, or quotient/remainder
//   flags                : {N, Z} of result_lo
//   dz                   : divide-by-zero indicator, valid with done
module arm_muldiv
  import arm_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [1:0]       flags,
  output logic             dz
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned ACC_W = 2 * WIDTH;

  muldiv_state_t    r_state;
  muldiv_op_t       r_op;
  logic [WIDTH-1:0] r_a;        // |a| for signed ops, raw a otherwise
  logic [WIDTH-1:0] r_b;        // |b| for signed ops, raw b otherwise
  logic             r_res_neg;  // product / quotient must be negated
  logic             r_rem_neg;  // remainder takes the dividend's sign
  logic             r_bz;       // b was zero at capture
  logic [ACC_W-1:0] r_acc;      // product, or {remainder, quotient}
  logic [CNT_W-1:0] r_cnt;

  logic             w_a_neg;
  logic             w_b_neg;
  logic             w_is_div;
  logic [WIDTH-1:0] w_acc_hi;
  logic [WIDTH-1:0] w_acc_lo;
  logic             w_mul_bit;
  logic [WIDTH:0]   w_mul_sum;
  logic             w_div_bit;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_trial;
  logic [ACC_W-1:0] w_acc_next;
  logic [ACC_W-1:0] w_prod;
  logic [WIDTH-1:0] w_fix_lo;
  logic [WIDTH-1:0] w_fix_hi;

  // Operand signs matter only for the signed ops (op[0] set).
  assign w_a_neg  = op[0] & a[WIDTH-1];
  assign w_b_neg  = op[0] & b[WIDTH-1];
  assign w_is_div = (r_op == UDIV) || (r_op == SDIV);
  assign w_acc_hi = r_acc[ACC_W-1:WIDTH];
  assign w_acc_lo = r_acc[WIDTH-1:0];

  // Multiply step: add the multiplicand into the high half when the current
  // multiplier bit is set, then shift the whole accumulator right by one.
  assign w_mul_bit = r_b[r_cnt];
  assign w_mul_sum = {1'b0, w_acc_hi} + (w_mul_bit ? {1'b0, r_a} : '0);

  // Restoring divide step: bring down the next dividend bit (MSB first);
  // the W+1-bit partial remainder keeps the trial subtraction exact.
  assign w_div_bit = r_a[CNT_W'(WIDTH-1) - r_cnt];
  assign w_rem_sh  = {w_acc_hi, w_div_bit};
  assign w_q_bit   = (w_rem_sh >= {1'b0, r_b});
  assign w_trial   = WIDTH'(w_rem_sh - {1'b0, r_b});

  // When no quotient bit is produced the shifted remainder is below b, so
  // its top bit is zero and dropping it loses nothing.
  assign w_acc_next = w_is_div
    ? {(w_q_bit ? w_trial : w_rem_sh[WIDTH-1:0]), w_acc_lo[WIDTH-2:0], w_q_bit}
    : {w_mul_sum, w_acc_lo[WIDTH-1:1]};

  // Sign fix-up and divide-by-zero override, applied in the FIX cycle.
  always_comb begin
    w_prod   = ACC_W'(cond_neg(MAX_W'(r_acc), r_res_neg));
    w_fix_lo = w_prod[WIDTH-1:0];
    w_fix_hi = w_prod[ACC_W-1:WIDTH];
    if (w_is_div) begin
      if (r_bz) begin
        // Re-applying the dividend sign to |a| recovers the raw a.
        w_fix_lo = '0;
        w_fix_hi = WIDTH'(cond_neg(MAX_W'(r_a), r_rem_neg));
      end else begin
        w_fix_lo = WIDTH'(cond_neg(MAX_W'(w_acc_lo), r_res_neg));
        w_fix_hi = WIDTH'(cond_neg(MAX_W'(w_acc_hi), r_rem_neg));
      end
    end
  end

  assign busy = (r_state == CALC) || (r_state == FIX);

  // Sequencer, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      done      <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      flags     <= 2'b00;
      dz        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_op      <= muldiv_op_t'(op);
            r_a       <= WIDTH'(cond_neg(MAX_W'(a), w_a_neg));
            r_b       <= WIDTH'(cond_neg(MAX_W'(b), w_b_neg));
            r_res_neg <= w_a_neg ^ w_b_neg;
            r_rem_neg <= w_a_neg;
            r_bz      <= (b == '0);
            r_acc     <= '0;
            r_cnt     <= '0;
            r_state   <= CALC;
          end else begin
            r_state <= IDLE;
          end
        end
        CALC: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH-1)) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          result_lo <= w_fix_lo;
          result_hi <= w_fix_hi;
          flags     <= {w_fix_lo[WIDTH-1], (w_fix_lo == '0)};
          dz        <= w_is_div & r_bz;
          done      <= 1'b1;
          r_state   <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arm_muldiv.sv
// Scoreboard bench for arm_muldiv (WIDTH = 32): the stimulus process pushes
// hand-computed results with their due cycle; a monitor pops on done.
module tb_arm_muldiv;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
  logic [1:0]  flags;
  logic        dz;

  arm_muldiv #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result_lo (result_lo),
    .result_hi (result_hi),
    .flags     (flags),
    .dz        (dz)
  );

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
    int          due;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   run   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: compare every done pulse against the head of the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      run = 0;
    end else begin
      if (done) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_done: got done=1 expected no pending op (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          chk("result_lo",  64'(result_lo), 64'(e.lo));
          chk("result_hi",  64'(result_hi), 64'(e.hi));
          chk("flags",      64'(flags),     64'({e.lo[31], (e.lo == 32'd0)}));
          chk("dz",         64'(dz),        64'(e.dz));
          chk("done_cycle", 64'(cyc),       64'(e.due));
          chk("busy_len",   64'(run),       64'(33));
        end
      end
      run = busy ? run + 1 : 0;
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] elo, input logic [31:0] ehi, input logic edz);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    q.push_back('{lo: elo, hi: ehi, dz: edz, due: cyc + 34});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_lo",   64'(result_lo), 64'(0));
    chk("rst_hi",   64'(result_hi), 64'(0));
    chk("rst_flags", 64'(flags), 64'(0));
    chk("rst_dz",   64'(dz), 64'(0));
    reset = 1'b0;

    // Multiply
    issue(2'b00, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 32'h00000001, 1'b0);
    wait_empty();
    issue(2'b01, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0);
    wait_empty();
    issue(2'b01, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b0);
    wait_empty();
    issue(2'b00, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000, 1'b0);
    wait_empty();

    // Divide
    issue(2'b10, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0);
    wait_empty();
    issue(2'b11, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
    wait_empty();
    issue(2'b11, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0);
    wait_empty();

    // Divide by zero and signed overflow
    issue(2'b10, 32'd5,        32'd0,        32'd0,        32'd5,        1'b1);
    wait_empty();
    issue(2'b11, 32'hFFFFFFFB, 32'd0,        32'd0,        32'hFFFFFFFB, 1'b1);
    wait_empty();
    issue(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0);
    wait_empty();

    // start held high: a new op is accepted in each DONE cycle
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'h00010000; b = 32'h00010000;
    q.push_back('{lo: 32'd0, hi: 32'd1, dz: 1'b0, due: cyc + 34});
    repeat (34) @(negedge clk);
    op = 2'b10; a = 32'hFFFFFFFF; b = 32'h10;
    q.push_back('{lo: 32'h0FFFFFFF, hi: 32'hF, dz: 1'b0, due: cyc + 34});
    repeat (34) @(negedge clk);
    op = 2'b01; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    q.push_back('{lo: 32'd1, hi: 32'd0, dz: 1'b0, due: cyc + 34});
    @(negedge clk);
    start = 1'b0;
    wait_empty();

    // start pulse with new operands mid-CALC is ignored
    issue(2'b00, 32'd7, 32'd6, 32'd42, 32'd0, 1'b0);
    repeat (8) @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd123; b = 32'd0;
    @(negedge clk);
    start = 1'b0;
    wait_empty();

    // reset in the 10th CALC cycle discards the op and clears outputs
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'h12345678; b = 32'h10;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy",  64'(busy), 64'(0));
    chk("mid_rst_done",  64'(done), 64'(0));
    chk("mid_rst_lo",    64'(result_lo), 64'(0));
    chk("mid_rst_hi",    64'(result_hi), 64'(0));
    chk("mid_rst_flags", 64'(flags), 64'(0));
    chk("mid_rst_dz",    64'(dz), 64'(0));
    reset = 1'b0;
    issue(2'b00, 32'd3, 32'd4, 32'd12, 32'd0, 1'b0);
    wait_empty();

    repeat (40) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
